// File: rtl/past_sequence_recover.sv
// Reconstructs raw samples from a stream of 2^N-sample window sums.
// Uses x[n] = y[n] - y[n-1] + x[n-W] over a W-deep circular history.
module past_sequence_recover #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] inp,
  output logic          out_valid,
  output logic [DW-1:0] outp,
  output logic          primed
);

  localparam int W = 1 << N;
  localparam logic [N:0] FILL_FULL = (N+1)'(W);

  logic [DW-1:0] hist [W];
  logic [DW-1:0] y_prev;
  logic [N-1:0]  wr_ptr;
  logic [N:0]    fill;

  logic          accept;
  logic [DW-1:0] x_new;
  logic [N:0]    fill_next;

  assign accept    = in_valid & ~clr;
  // hist[wr_ptr] is x[n-W] once the window has filled, zero before that
  assign x_new     = inp - y_prev + hist[wr_ptr];
  assign fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) hist[i] <= '0;
      y_prev    <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      outp      <= '0;
      primed    <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < W; i++) hist[i] <= '0;
      y_prev    <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      outp      <= '0;
      primed    <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        hist[wr_ptr] <= x_new;
        outp         <= x_new;
        wr_ptr       <= wr_ptr + 1'b1;
        y_prev       <= inp;
        fill         <= fill_next;
        primed       <= (fill_next == FILL_FULL);
      end
    end
  end

endmodule

// File: tb/tb_past_sequence_recover.sv
// Scoreboard bench for past_sequence_recover: driver queues expected samples,
// an independent monitor pops and compares on every out_valid.
module tb_past_sequence_recover;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] inp = '0;
  logic       out_valid;
  logic [7:0] outp;
  logic       primed;

  past_sequence_recover #(.N(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .inp(inp),
    .out_valid(out_valid), .outp(outp), .primed(primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic       pr;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  int         n_pass = 0;
  int         n_tot  = 0;
  int         cyc    = 0;
  int         fill   = 0;
  logic       chk_hold = 1'b0;
  logic [7:0] last_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_out: got outp=%0d with no sample pending (cycle %0d)", outp, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("outp", outp, e.x);
        check("primed", primed, e.pr);
        check("latency", cyc, e.due);
      end
      last_out = outp;
    end else if (rst_n && chk_hold) begin
      check("outp_hold", outp, last_out);
    end
  end

  // One driver cycle; accepted sums queue their expected sample.
  task automatic drive(input logic v, input logic [7:0] y, input logic c, input logic [7:0] xexp);
    exp_t e;
    @(posedge clk); #1;
    in_valid = v; inp = y; clr = c;
    if (c) fill = 0;
    else if (v) begin
      fill = (fill == 16) ? 16 : fill + 1;
      e.x = xexp; e.pr = (fill == 16); e.due = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  // Window sum of x[k] = k+1 ending at n, with x = 0 before the stream.
  function automatic logic [7:0] ramp_sum(input int n);
    int s = 0;
    for (int k = (n >= 15 ? n - 15 : 0); k <= n; k++) s += k + 1;
    return 8'(s);
  endfunction

  task automatic ramp(input int count, input bit stall);
    for (int n = 0; n < count; n++) begin
      drive(1'b1, ramp_sum(n), 1'b0, 8'(n + 1));
      if (stall && (n % 5 == 4)) begin
        chk_hold = 1'b1;
        idle(3);
        chk_hold = 1'b0;
      end
    end
  endtask

  task automatic impulse();
    for (int n = 0; n < 24; n++)
      drive(1'b1, (n < 16) ? 8'd1 : 8'd0, 1'b0, (n == 0) ? 8'd1 : 8'd0);
    idle(3);
  endtask

  task automatic flush();
    drive(1'b0, 8'd0, 1'b1, 8'd0);
    idle(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_outp", outp, 0);
    check("rst_primed", primed, 0);
    #14 rst_n = 1'b1;

    impulse();
    check("impulse_primed_held", primed, 1);

    flush();
    check("clr_primed", primed, 0);
    ramp(40, 1'b0);
    idle(3);

    flush();
    for (int n = 0; n < 40; n++)
      drive(1'b1, 8'(200 * ((n + 1 < 16) ? n + 1 : 16)), 1'b0, 8'd200);
    idle(3);

    flush();
    ramp(40, 1'b1);
    idle(3);

    flush();
    ramp(10, 1'b0);
    drive(1'b1, ramp_sum(10), 1'b1, 8'd0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check("clr_mid_primed", primed, 0);
    check("clr_mid_out_valid", out_valid, 0);
    check("clr_mid_outp", outp, 0);
    ramp(40, 1'b0);
    idle(3);
    check("drain_before_reset", exp_q.size(), 0);

    flush();
    ramp(20, 1'b0);
    @(posedge clk); #2;
    in_valid = 1'b0;
    check("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_outp", outp, 0);
    check("async_primed", primed, 0);
    exp_q.delete();
    fill = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;

    impulse();
    idle(2);
    check("final_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
